// File: rtl/constant_block_server.sv
`default_nettype none
// ============================================================================
//  Module      : constant_block_server
//  Description : Stores one wide constant (k, N, N^2, R^2 mod N) as a set of
//                REGISTER_SIZE-bit blocks and serves it block-by-block,
//                cyclically, to a consumer using a block + consumed handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module constant_block_server #(
    parameter int REGISTER_SIZE    = 32,
    parameter int NUM_BLOCKS       = 128,
    parameter int PASS_COUNT_WIDTH = 16,
    localparam int IDX_W           = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        load_valid_in,
    input  logic [REGISTER_SIZE-1:0]    load_block_in,
    output logic                        load_done_out,
    input  logic                        restart_in,
    input  logic                        consumed_in,
    output logic [REGISTER_SIZE-1:0]    block_out,
    output logic                        block_valid_out,
    output logic [IDX_W-1:0]            block_index_out,
    output logic                        wrap_out,
    output logic [PASS_COUNT_WIDTH-1:0] pass_count_out
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]            c_LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [PASS_COUNT_WIDTH-1:0] c_PASS_MAX = '1;

    // Register-based storage so a read is available on the very next cycle
    logic [REGISTER_SIZE-1:0]    r_mem [NUM_BLOCKS];

    state_t                      r_state;
    logic [IDX_W-1:0]            r_load_ptr;
    logic [IDX_W-1:0]            r_rd_idx;
    logic [REGISTER_SIZE-1:0]    r_block;
    logic                        r_valid;
    logic                        r_done;
    logic                        r_wrap;
    logic [PASS_COUNT_WIDTH-1:0] r_pass;

    state_t                      w_state_next;
    logic [IDX_W-1:0]            w_load_ptr_next;
    logic [IDX_W-1:0]            w_rd_idx_next;
    logic [REGISTER_SIZE-1:0]    w_block_next;
    logic                        w_valid_next;
    logic                        w_done_next;
    logic                        w_wrap_next;
    logic [PASS_COUNT_WIDTH-1:0] w_pass_next;
    logic [IDX_W-1:0]            w_wr_idx;
    logic                        w_wr_last;

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-output decode; a load always takes priority over
    // serving, and restart takes priority over consume.
    always_comb begin
        w_state_next    = r_state;
        w_load_ptr_next = r_load_ptr;
        w_rd_idx_next   = r_rd_idx;
        w_block_next    = r_block;
        w_valid_next    = r_valid;
        w_done_next     = 1'b0;
        w_wrap_next     = 1'b0;
        w_pass_next     = r_pass;
        // Only an in-progress load continues at the load pointer; a load
        // starting from EMPTY or READY always begins at block 0.
        w_wr_idx        = (r_state == ST_LOADING) ? r_load_ptr : '0;
        w_wr_last       = (w_wr_idx == c_LAST_IDX);

        if (load_valid_in) begin
            w_rd_idx_next = '0;
            w_pass_next   = '0;
            if (w_wr_last) begin
                w_state_next    = ST_READY;
                w_load_ptr_next = '0;
                w_valid_next    = 1'b1;
                w_done_next     = 1'b1;
                // Single-block constants present the block being written now
                w_block_next    = (w_wr_idx == '0) ? load_block_in : r_mem[0];
            end else begin
                w_state_next    = ST_LOADING;
                w_load_ptr_next = w_wr_idx + 1'b1;
                w_valid_next    = 1'b0;
            end
        end else if (r_state == ST_READY) begin
            if (restart_in) begin
                w_rd_idx_next = '0;
                w_block_next  = r_mem[0];
            end else if (consumed_in) begin
                if (r_rd_idx == c_LAST_IDX) begin
                    w_rd_idx_next = '0;
                    w_wrap_next   = 1'b1;
                    w_pass_next   = (r_pass == c_PASS_MAX) ? r_pass : r_pass + 1'b1;
                end else begin
                    w_rd_idx_next = r_rd_idx + 1'b1;
                end
                w_block_next = r_mem[w_rd_idx_next];
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_load_ptr <= '0;
            r_rd_idx   <= '0;
            r_block    <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
            r_pass     <= '0;
        end else begin
            r_load_ptr <= w_load_ptr_next;
            r_rd_idx   <= w_rd_idx_next;
            r_block    <= w_block_next;
            r_valid    <= w_valid_next;
            r_done     <= w_done_next;
            r_wrap     <= w_wrap_next;
            r_pass     <= w_pass_next;
        end
    end

    // Constant storage write; contents are deliberately not reset
    always_ff @(posedge clk_in) begin
        if (rst_in && load_valid_in) begin
            r_mem[w_wr_idx] <= load_block_in;
        end
    end

    assign load_done_out   = r_done;
    assign block_out       = r_block;
    assign block_valid_out = r_valid;
    assign block_index_out = r_rd_idx;
    assign wrap_out        = r_wrap;
    assign pass_count_out  = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_constant_block_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_constant_block_server
//  Description : Self-checking bench for constant_block_server with directed
//                scenarios followed by randomized traffic, all checked against
//                a behavioural model of the served constant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_constant_block_server;

    localparam int RS = 32;
    localparam int NB = 4;
    localparam int PW = 2;
    localparam int IW = 2;
    localparam int PASS_MAX = (1 << PW) - 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          load_valid_in;
    logic [RS-1:0] load_block_in;
    logic          load_done_out;
    logic          restart_in;
    logic          consumed_in;
    logic [RS-1:0] block_out;
    logic          block_valid_out;
    logic [IW-1:0] block_index_out;
    logic          wrap_out;
    logic [PW-1:0] pass_count_out;

    constant_block_server #(
        .REGISTER_SIZE   (RS),
        .NUM_BLOCKS      (NB),
        .PASS_COUNT_WIDTH(PW)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .load_valid_in  (load_valid_in),
        .load_block_in  (load_block_in),
        .load_done_out  (load_done_out),
        .restart_in     (restart_in),
        .consumed_in    (consumed_in),
        .block_out      (block_out),
        .block_valid_out(block_valid_out),
        .block_index_out(block_index_out),
        .wrap_out       (wrap_out),
        .pass_count_out (pass_count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: the stored constant, how many blocks of the current
    // load have arrived, and where the reader is within the constant.
    logic [RS-1:0] m_mem [NB];
    int            m_loaded = 0;
    int            m_idx    = 0;
    int            m_pass   = 0;
    bit            m_valid  = 0;
    bit            m_done   = 0;
    bit            m_wrap   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        m_done = 0;
        m_wrap = 0;
        if (!rst_in) begin
            m_loaded = 0;
            m_idx    = 0;
            m_pass   = 0;
            m_valid  = 0;
        end else if (load_valid_in) begin
            if (m_loaded == NB) m_loaded = 0;
            m_mem[m_loaded] = load_block_in;
            m_loaded++;
            m_idx  = 0;
            m_pass = 0;
            if (m_loaded == NB) begin
                m_valid = 1;
                m_done  = 1;
            end else begin
                m_valid = 0;
            end
        end else if (m_valid) begin
            if (restart_in) begin
                m_idx = 0;
            end else if (consumed_in) begin
                m_idx = (m_idx + 1) % NB;
                if (m_idx == 0) begin
                    m_wrap = 1;
                    if (m_pass < PASS_MAX) m_pass++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("block_valid", block_valid_out, m_valid);
        check("load_done", load_done_out, m_done);
        check("wrap", wrap_out, m_wrap);
        check("index", block_index_out, m_idx);
        check("pass_count", pass_count_out, m_pass);
        if (!rst_in) check("block_in_reset", block_out, 0);
        if (m_valid) check("block", block_out, m_mem[m_idx]);
    endtask

    task automatic cycle(input bit rst_v, input bit lv, input logic [RS-1:0] lb,
                         input bit rs, input bit cons);
        rst_in        = rst_v;
        load_valid_in = lv;
        load_block_in = lb;
        restart_in    = rs;
        consumed_in   = cons;
        @(posedge clk_in);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic load4(input logic [RS-1:0] b0, input logic [RS-1:0] b1,
                         input logic [RS-1:0] b2, input logic [RS-1:0] b3);
        cycle(1, 1, b0, 0, 0);
        cycle(1, 1, b1, 0, 0);
        cycle(1, 1, b2, 0, 0);
        cycle(1, 1, b3, 0, 0);
        check("load_done_pulse", load_done_out, 1);
        check("first_block", block_out, b0);
        check("first_index", block_index_out, 0);
    endtask

    logic [RS-1:0] exp_seq [5];
    logic [PW-1:0] exp_pass [5];

    initial begin
        rst_in        = 1'b0;
        load_valid_in = 1'b0;
        load_block_in = '0;
        restart_in    = 1'b0;
        consumed_in   = 1'b0;

        // Reset then load
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        load4(32'h11, 32'h22, 32'h33, 32'h44);
        cycle(1, 0, 0, 0, 0);
        check("done_one_cycle", load_done_out, 0);

        // Streaming with wrap
        exp_seq[0] = 32'h22; exp_seq[1] = 32'h33; exp_seq[2] = 32'h44;
        exp_seq[3] = 32'h11; exp_seq[4] = 32'h22;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 0, 1);
            check("stream_block", block_out, exp_seq[i]);
            check("stream_wrap", wrap_out, (i == 3));
        end
        check("stream_pass", pass_count_out, 1);

        // Gapped consume, then restart together with consume
        cycle(1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1);
        check("gap_consume", block_out, 32'h22);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        check("gap_hold", block_out, 32'h22);
        cycle(1, 0, 0, 1, 1);
        check("restart_block", block_out, 32'h11);
        check("restart_wrap", wrap_out, 0);

        // Restart wins over consume even at the last block
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);
        check("at_last", block_index_out, 3);
        cycle(1, 0, 0, 1, 1);
        check("restart_last_idx", block_index_out, 0);
        check("restart_last_wrap", wrap_out, 0);

        // Reload mid-pass, with a gap in the load
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 32'hA0, 0, 1);
        check("reload_valid", block_valid_out, 0);
        cycle(1, 1, 32'hA1, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 32'hA2, 1, 0);
        cycle(1, 1, 32'hA3, 0, 0);
        check("reload_done", load_done_out, 1);
        check("reload_block", block_out, 32'hA0);
        check("reload_pass", pass_count_out, 0);

        // Reset mid-load
        cycle(1, 1, 32'hB0, 0, 0);
        cycle(1, 1, 32'hB1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 1, 1);
        check("empty_ignores", block_valid_out, 0);
        load4(32'h11, 32'h22, 32'h33, 32'h44);

        // Saturating pass counter
        exp_pass[0] = 2'd1; exp_pass[1] = 2'd2; exp_pass[2] = 2'd3;
        exp_pass[3] = 2'd3; exp_pass[4] = 2'd3;
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < NB; b++) cycle(1, 0, 0, 0, 1);
            check("sat_wrap", wrap_out, 1);
            check("sat_pass", pass_count_out, exp_pass[p]);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 64) != 0, ($urandom % 8) == 0, $urandom,
                  ($urandom % 6) == 0, ($urandom % 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/constant_block_server.md
Name: constant_block_server

Overview:
- Streaming supplier for wide constants (k, N, N^2, R^2 mod N) consumed block-by-block by the Montgomery/multiplier pipeline.
- Sits on the producing side of the block+consumed handshake. The consumer asserts a combinational "consumed" strobe, and this block presents the next constant block on the following cycle.
- The constant is loaded once, LSB block first, then served cyclically, wrapping so that repeated reductions can reuse it.

Parameters:
- REGISTER_SIZE, 32, width of one block in bits.
- NUM_BLOCKS, 128, blocks per constant (128x32 = 4096 bits).
- PASS_COUNT_WIDTH, 16, width of the completed-pass counter.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous reset, active-low (0 = reset).
- load_valid_in  input  1  load_block_in is valid this cycle; one block is written.
- load_block_in  input  REGISTER_SIZE  constant block, LSB block first.
- load_done_out  output  1  single-cycle pulse: final block of the constant has been written.
- restart_in  input  1  rewind the read pointer to block 0.
- consumed_in  input  1  consumer has taken block_out this cycle; advance (driven combinationally by the consumer).
- block_out  output  REGISTER_SIZE  current constant block (registered).
- block_valid_out  output  1  a complete constant is stored and block_out is meaningful.
- block_index_out  output  $clog2(NUM_BLOCKS)  index of the block currently on block_out.
- wrap_out  output  1  single-cycle pulse: last block consumed, pointer wrapped to 0.
- pass_count_out  output  PASS_COUNT_WIDTH  number of completed full passes since the last load.

Behaviour:
- Storage: NUM_BLOCKS x REGISTER_SIZE register array. Read must be usable the next cycle, so no 2-cycle BRAM latency.
- Reset (rst_in == 0 at a clock edge), from any state, including mid-load or mid-pass:
  - state goes to EMPTY;
  - load pointer, read pointer and pass_count_out clear to 0;
  - block_out = 0, block_valid_out = 0, load_done_out = 0, wrap_out = 0, block_index_out = 0;
  - array contents need not be cleared.
- FSM states: EMPTY, LOADING, READY.
  - EMPTY: load_valid_in writes block 0, load pointer goes to 1, next state LOADING. consumed_in and restart_in are ignored.
  - LOADING: each load_valid_in writes at the load pointer and increments it. Gaps in load_valid_in are allowed.
  - LOADING, write of block NUM_BLOCKS-1 at cycle c: at c+1, state is READY, load_done_out = 1 (one cycle), block_valid_out = 1, block_out = block 0, block_index_out = 0, pass_count_out = 0.
  - READY: load_valid_in overwrites block 0 and goes to LOADING. block_valid_out drops the next cycle, the read pointer resets, and that cycle's consumed_in is ignored.
  - NUM_BLOCKS == 1: the first load goes straight to READY.
- Serving, READY only:
  - consumed_in at cycle c with index i < NUM_BLOCKS-1: at c+1, block_out = mem[i+1] and block_index_out = i+1.
  - consumed_in at i == NUM_BLOCKS-1: at c+1, block_out = mem[0], block_index_out = 0, wrap_out = 1, and pass_count_out increments.
  - pass_count_out saturates at all-ones; it does not wrap.
  - Without consumed_in, block_out and block_index_out hold.
  - Back-to-back consumed_in every cycle advances one block per cycle with no bubbles.
- restart_in in READY: at c+1, block_out = mem[0] and block_index_out = 0. No wrap_out pulse, and pass_count_out is unchanged.
- Simultaneous events:
  - restart_in and consumed_in together: restart wins, so index goes to 0 with no wrap pulse, even if the index was NUM_BLOCKS-1.
  - load_valid_in together with restart_in or consumed_in in READY: load wins.
- load_valid_in never stalls: there is no ready output, and every asserted cycle is a write.

Test Plan (REGISTER_SIZE=32, NUM_BLOCKS=4):
- Reset then load: hold rst_in=0 for 2 cycles, then load 0x11,0x22,0x33,0x44 on consecutive cycles -> all outputs 0 during reset; the cycle after the 0x44 write, load_done_out=1 for exactly one cycle, block_valid_out=1, block_out=0x11, block_index_out=0.
- Streaming with wrap: consumed_in high 5 consecutive cycles -> block_out sequence 0x22,0x33,0x44,0x11,0x22; wrap_out pulses once, on the cycle block_out returns to 0x11; pass_count_out goes 0 -> 1.
- Gapped consume and restart: consume once (block_out=0x22), idle 3 cycles (holds 0x22), assert restart_in together with consumed_in -> block_out=0x11, index 0, no wrap_out, pass_count_out unchanged.
- Reload mid-pass: at index 2, assert load_valid_in with 0xA0 plus consumed_in -> block_valid_out=0 next cycle, consumed ignored; load 0xA1,0xA2,0xA3 with one idle gap -> load_done_out pulses, block_out=0xA0, pass_count_out=0.
- Reset mid-load: after writing 2 blocks, drive rst_in=0 for one cycle -> state EMPTY, block_valid_out=0; consumed_in pulses are ignored; a fresh 4-block load behaves as in the reset-then-load case.
- Saturation: with PASS_COUNT_WIDTH=2, run 5 full passes -> pass_count_out goes 1,2,3,3,3 and wrap_out still pulses on every pass.
